// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

  localparam int DATA_W  = 32;
  localparam int TMO_W   = 8;
  localparam int RETRY_W = 2;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Top-level sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } sysid_state_t;

  // Single-read engine states.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_state_t;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
  import sysid_pkg::*;

  logic              address;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_boot_checker_avm_single_read.sv
// One Avalon-MM word read: request with waitrequest hold, response timeout
// and bounded retry. Returns the word, a retry request or a final timeout.
module avm_single_read
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_go,
  input  logic                 i_address,
  sysid_boot_checker_if.master avm,
  output logic                 o_accepted,
  output logic                 o_data_valid,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_retry,
  output logic                 o_timed_out
);

  rd_state_t          r_state;
  logic               r_read;
  logic               r_address;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [RETRY_W-1:0] r_retry;

  logic w_waiting;
  logic w_limit;
  logic w_can_retry;

  assign avm.read    = r_read;
  assign avm.address = r_address;

  assign w_waiting    = (r_state == RD_WAIT);
  assign o_accepted   = r_read & ~avm.waitrequest;
  assign o_data_valid = w_waiting & avm.readdatavalid;
  assign o_data       = avm.readdata;

  // Data arriving on the limit cycle wins over the timeout.
  assign w_limit     = w_waiting & ~avm.readdatavalid &
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign w_can_retry = (r_retry < RETRY_W'(MAX_RETRY));
  assign o_retry     = w_limit & w_can_retry;
  assign o_timed_out = w_limit & ~w_can_retry;

  // Request/wait sequencing; the retry count survives only across timeouts of one word.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state   <= RD_IDLE;
      r_read    <= 1'b0;
      r_address <= 1'b0;
      r_tmo_cnt <= '0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (i_go) begin
            r_read    <= 1'b1;
            r_address <= i_address;
            r_state   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (o_accepted) begin
            r_read    <= 1'b0;
            r_tmo_cnt <= '0;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (o_data_valid) begin
            r_retry <= '0;
            r_state <= RD_IDLE;
          end else if (o_retry) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_state <= RD_IDLE;
          end else if (o_timed_out) begin
            r_retry <= '0;
            r_state <= RD_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID and timestamp words, compares them with the build-time
// values and releases the system only on a matching hardware image.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1493910150,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  sysid_boot_checker_if.master avm,
  output logic [DATA_W-1:0]    o_id_value,
  output logic [DATA_W-1:0]    o_ts_value,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_fail_mismatch,
  output logic                 o_fail_timeout,
  output logic                 o_sys_release
);

  sysid_state_t      r_state;
  logic              r_go;
  logic              r_auto;

  logic              w_go_addr;
  logic              w_accepted;
  logic              w_data_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_retry;
  logic              w_timed_out;

  // r_go is only ever high while sitting in a REQ state.
  assign w_go_addr = (r_state == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  avm_single_read #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_read (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_go         (r_go),
    .i_address    (w_go_addr),
    .avm          (avm),
    .o_accepted   (w_accepted),
    .o_data_valid (w_data_valid),
    .o_data       (w_data),
    .o_retry      (w_retry),
    .o_timed_out  (w_timed_out)
  );

  // Word sequencing, comparison and registered status outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state         <= ST_IDLE;
      r_go            <= 1'b0;
      r_auto          <= AUTO_START;
      o_id_value      <= '0;
      o_ts_value      <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_fail_mismatch <= 1'b0;
      o_fail_timeout  <= 1'b0;
      o_sys_release   <= 1'b0;
    end else begin
      r_go   <= 1'b0;
      r_auto <= 1'b0;
      case (r_state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          // sys_release is deliberately left alone on a re-run.
          if (i_start || r_auto) begin
            r_state         <= ST_ID_REQ;
            r_go            <= 1'b1;
            o_busy          <= 1'b1;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_fail_mismatch <= 1'b0;
            o_fail_timeout  <= 1'b0;
          end
        end
        ST_ID_REQ: if (w_accepted) r_state <= ST_ID_WAIT;
        ST_ID_WAIT: begin
          if (w_data_valid) begin
            o_id_value <= w_data;
            r_state    <= ST_TS_REQ;
            r_go       <= 1'b1;
          end else if (w_retry) begin
            r_state <= ST_ID_REQ;
            r_go    <= 1'b1;
          end else if (w_timed_out) begin
            r_state        <= ST_FAIL;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            o_fail_timeout <= 1'b1;
          end
        end
        ST_TS_REQ: if (w_accepted) r_state <= ST_TS_WAIT;
        ST_TS_WAIT: begin
          if (w_data_valid) begin
            o_ts_value <= w_data;
            r_state    <= ST_CHECK;
          end else if (w_retry) begin
            r_state <= ST_TS_REQ;
            r_go    <= 1'b1;
          end else if (w_timed_out) begin
            r_state        <= ST_FAIL;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            o_fail_timeout <= 1'b1;
          end
        end
        ST_CHECK: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          if ((o_id_value == EXPECTED_ID) && (o_ts_value == EXPECTED_TS)) begin
            r_state       <= ST_PASS;
            o_pass        <= 1'b1;
            o_sys_release <= 1'b1;
          end else begin
            r_state         <= ST_FAIL;
            o_fail_mismatch <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: dut_a auto-starts against a zero-wait slave,
// dut_b is started by pulses against a configurable slave and a result model.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1493910150;
  localparam int          TMO     = 255;
  localparam int          RETRIES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, start_a, start_b;
  logic [31:0] a_id, a_ts, b_id, b_ts;
  logic a_busy, a_done, a_pass, a_mis, a_tmo, a_rel;
  logic b_busy, b_done, b_pass, b_mis, b_tmo, b_rel;

  sysid_boot_checker_if ifa ();
  sysid_boot_checker_if ifb ();

  sysid_boot_checker #(.AUTO_START(1'b1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_a_n), .i_start(start_a), .avm(ifa),
    .o_id_value(a_id), .o_ts_value(a_ts), .o_busy(a_busy), .o_done(a_done),
    .o_pass(a_pass), .o_fail_mismatch(a_mis), .o_fail_timeout(a_tmo),
    .o_sys_release(a_rel));

  sysid_boot_checker #(.AUTO_START(1'b0)) dut_b (
    .i_clock(clk), .i_reset_n(rst_b_n), .i_start(start_b), .avm(ifb),
    .o_id_value(b_id), .o_ts_value(b_ts), .o_busy(b_busy), .o_done(b_done),
    .o_pass(b_pass), .o_fail_mismatch(b_mis), .o_fail_timeout(b_tmo),
    .o_sys_release(b_rel));

  int checks = 0;
  int errors = 0;

  // slave B configuration, per word address
  int          cfg_w [2];
  int          cfg_d [2];
  bit          cfg_nr[2];
  logic [31:0] cfg_v [2];
  int          acc_cnt[2];
  int          hold_err;
  bit          stray_rdv;

  // behavioural model state
  logic [31:0] m_id, m_ts;
  bit          m_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave A: never stalls, answers one cycle after each acceptance
  logic a_acc = 1'b0, a_acc_addr = 1'b0;
  initial begin
    ifa.waitrequest = 1'b0; ifa.readdatavalid = 1'b0; ifa.readdata = '0;
    forever begin
      @(negedge clk);
      ifa.readdatavalid = a_acc;
      ifa.readdata      = a_acc_addr ? EXP_TS : EXP_ID;
      a_acc      = ifa.read;
      a_acc_addr = ifa.address;
    end
  end

  // slave B: stalls cfg_w cycles, responds in wait cycle cfg_d, checks request hold
  initial begin
    int stall, pend;
    bit pend_addr, hold_valid, hold_addr;
    stall = 0; pend = 0; pend_addr = 0; hold_valid = 0; hold_addr = 0;
    ifb.waitrequest = 1'b0; ifb.readdatavalid = 1'b0; ifb.readdata = '0;
    forever begin
      @(negedge clk);
      ifb.readdatavalid = 1'b0;
      if (!rst_b_n) begin
        pend = 0; stall = 0; hold_valid = 0;
      end
      if (stray_rdv) begin
        ifb.readdatavalid = 1'b1;
        ifb.readdata      = 32'hDEADBEEF;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ifb.readdatavalid = 1'b1;
          ifb.readdata      = cfg_v[pend_addr];
        end
      end
      if (ifb.read === 1'b1) begin
        if (hold_valid && ifb.address !== hold_addr) hold_err++;
        if (stall < cfg_w[ifb.address]) begin
          ifb.waitrequest = 1'b1;
          stall++;
          hold_valid = 1; hold_addr = ifb.address;
        end else begin
          ifb.waitrequest = 1'b0;
          stall = 0; hold_valid = 0;
          acc_cnt[ifb.address]++;
          if (!cfg_nr[ifb.address]) begin
            pend = cfg_d[ifb.address]; pend_addr = ifb.address;
          end
        end
      end else begin
        if (hold_valid) hold_err++;
        hold_valid = 0;
        ifb.waitrequest = 1'b0;
      end
    end
  end

  // One start-pulsed check on dut_b; expectations come from the word timing rules.
  task automatic run_b(input string tag, input int w0, input int d0, input bit nr0,
                       input logic [31:0] v0, input int w1, input int d1, input bit nr1,
                       input logic [31:0] v1, input int mid_k);
    int exp_lat, e_acc0, e_acc1, n, overlap;
    bit exp_pass, exp_mis, exp_tmo;
    cfg_w[0] = w0; cfg_d[0] = d0; cfg_nr[0] = nr0; cfg_v[0] = v0;
    cfg_w[1] = w1; cfg_d[1] = d1; cfg_nr[1] = nr1; cfg_v[1] = v1;
    acc_cnt[0] = 0; acc_cnt[1] = 0; hold_err = 0;
    // a word attempt costs 2 + stalls + response cycle; a timed-out one waits 256 cycles
    if (nr0) begin
      exp_lat = (1 + RETRIES) * (3 + w0 + TMO); e_acc0 = 1 + RETRIES; e_acc1 = 0;
    end else begin
      m_id = v0; e_acc0 = 1;
      if (nr1) begin
        exp_lat = (2 + w0 + d0) + (1 + RETRIES) * (3 + w1 + TMO); e_acc1 = 1 + RETRIES;
      end else begin
        m_ts = v1; e_acc1 = 1;
        exp_lat = (2 + w0 + d0) + (2 + w1 + d1) + 1;
      end
    end
    exp_pass = !nr0 && !nr1 && (v0 == EXP_ID) && (v1 == EXP_TS);
    exp_mis  = !nr0 && !nr1 && !exp_pass;
    exp_tmo  = nr0 || nr1;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    chk({tag, "/busy0"}, {b_busy, b_done, b_pass}, 3'b100);
    chk({tag, "/rel_kept"}, b_rel, m_rel);
    n = 0; overlap = 0;
    while (!b_done && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (b_busy && b_done) overlap++;
      start_b = (n == mid_k);
    end
    start_b = 1'b0;
    m_rel = m_rel | exp_pass;
    chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "/flags"}, {b_busy, b_done, b_pass, b_mis, b_tmo}, {1'b0, 1'b1, exp_pass, exp_mis, exp_tmo});
    chk({tag, "/release"}, b_rel, m_rel);
    chk({tag, "/id"}, b_id, m_id);
    chk({tag, "/ts"}, b_ts, m_ts);
    chk({tag, "/acc_id"}, 32'(acc_cnt[0]), 32'(e_acc0));
    chk({tag, "/acc_ts"}, 32'(acc_cnt[1]), 32'(e_acc1));
    chk({tag, "/hold"}, 32'(hold_err), 32'd0);
    chk({tag, "/busy_done_excl"}, 32'(overlap), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int w0, d0, w1, d1;
    logic [31:0] v0, v1;
    rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stray_rdv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cfg_w[i] = 0; cfg_d[i] = 1; cfg_nr[i] = 0; acc_cnt[i] = 0;
    end
    cfg_v[0] = EXP_ID; cfg_v[1] = EXP_TS; hold_err = 0;
    m_id = '0; m_ts = '0; m_rel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset/a_outs", {a_busy, a_done, a_pass, a_mis, a_tmo, a_rel, ifa.read}, '0);
    chk("reset/a_values", a_id | a_ts, '0);
    chk("reset/b_outs", {b_busy, b_done, b_pass, b_mis, b_tmo, b_rel, ifb.read}, '0);

    // auto start: ID_REQ on the first edge after release, done 7 edges later
    @(negedge clk); rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    chk("auto/busy_e0", {a_busy, a_done}, 2'b10);
    n = 0;
    while (!a_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("auto/latency", 32'(n), 32'd7);
    chk("auto/flags", {a_busy, a_done, a_pass, a_mis, a_tmo, a_rel}, 6'b011001);
    chk("auto/id", a_id, EXP_ID);
    chk("auto/ts", a_ts, EXP_TS);
    chk("noauto/b_idle", {b_busy, b_done, ifb.read}, 3'b000);

    run_b("wait5",       5, 1,   0, EXP_ID, 5, 1, 0, EXP_TS,        0);
    run_b("ts_mismatch", 0, 1,   0, EXP_ID, 0, 1, 0, 32'h12345678,  0);
    run_b("id_timeout",  0, 1,   1, EXP_ID, 0, 1, 0, EXP_TS,        0);
    run_b("rdv_at_256",  0, 256, 0, EXP_ID, 1, 2, 0, EXP_TS,        0);
    run_b("start_busy",  2, 3,   0, EXP_ID, 1, 1, 0, EXP_TS,        3);
    run_b("ts_timeout",  1, 2,   0, EXP_ID, 0, 1, 1, EXP_TS,        0);

    // reset while waiting on the timestamp, then a stray response in IDLE
    cfg_w[0] = 0; cfg_d[0] = 1; cfg_nr[0] = 0; cfg_v[0] = EXP_ID;
    cfg_w[1] = 0; cfg_d[1] = 1; cfg_nr[1] = 1; cfg_v[1] = EXP_TS;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid/in_ts_wait", {b_busy, ifb.address, ifb.read}, 3'b110);
    @(negedge clk); rst_b_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/outs", {b_busy, b_done, b_pass, b_mis, b_tmo, b_rel, ifb.read}, '0);
    chk("rst_mid/values", b_id | b_ts, '0);
    m_id = '0; m_ts = '0; m_rel = 1'b0;
    @(negedge clk); rst_b_n = 1'b1;
    @(posedge clk); #1; stray_rdv = 1'b1;
    @(posedge clk); #1; stray_rdv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray/outs", {b_busy, b_done, b_pass, b_mis, b_tmo, b_rel, ifb.read}, '0);
    chk("stray/values", b_id | b_ts, '0);
    run_b("after_reset", 0, 1, 0, EXP_ID, 0, 1, 0, EXP_TS, 0);

    for (int r = 0; r < 6; r++) begin
      w0 = $urandom_range(0, 3); d0 = $urandom_range(1, 4);
      w1 = $urandom_range(0, 3); d1 = $urandom_range(1, 4);
      v0 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      v1 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      run_b("random", w0, d0, 0, v0, w1, d1, 0, v1, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
